id_ex_buffer: RTL and testbench
===============================

// Module: id_ex_buffer
// PURPOSE
//  ID/EX pipeline register between iDecode and iExecute, with load-use hazard detection.
//  Captures decode controls and operands each cycle and presents them to execute one cycle later.
//  Inserts a bubble on a load-use hazard (rn/rm matches the load destination now in EX).
//  Also supports a branch flush and an external hold.
// PARAMETERS
//  WORD_W   64  datapath width (pc, operands, sign-extended immediate)
//  OPC_W    11  opcode field width
//  REG_W     5  register index width
//  ZERO_REG 31  index of XZR; never creates a hazard
// PORTS
//  clk                clk   in   1      rising-edge clock
//  reset              in    1      synchronous, active-high
//  valid_id           in    1      decode slot holds a real instruction
//  uncond_branch_id, branch_id, mem_read_id, mem_to_reg_id, mem_write_id, reg_write_id, ALU_src_id
//                     in    1 each decode control bits
//  ALU_op_id          in    2      ALU op class
//  opcode_id          in    OPC_W  instruction opcode
//  read_reg1_id       in    REG_W  rn index of decode instruction
//  read_reg2_id       in    REG_W  rm/rt index of decode instruction
//  write_register_id  in    REG_W  destination index
//  cur_pc_id, read_data1_id, read_data2_id, sign_extended_output_id  in  WORD_W each
//  flush_ie           in    1      branch taken downstream; kill the slot being written
//  hold_ie            in    1      execute not ready; freeze register contents
//  *_ie               out   same   registered copies of every *_id control/data input above
//  valid_ie           out   1      EX slot holds a real instruction
//  hazard_stall_id    out   1      combinational; hold PC and IF/ID this cycle
//  bubble_count       out   32     load-use bubbles inserted (see CONFIGURATION)
//  flush_count        out   32     flushed slots (see CONFIGURATION)
// BEHAVIOUR
//  Clock and reset:
//  - Single clock domain, clk.
//  - reset is synchronous and active-high, sampled at the rising edge of clk.
//  - In reset, all *_ie outputs, valid_ie and both counters go to 0.
//  Latency: 1 cycle from *_id to *_ie.
//  hazard_stall_id:
//  - Asserted when valid_ie & mem_read_ie & valid_id & (write_register_ie != ZERO_REG)
//    & (write_register_ie == read_reg1_id | write_register_ie == read_reg2_id).
//  - Forced to 0 while hold_ie or flush_ie is asserted.
//  Update priority at each edge (first match wins):
//  1. reset: clear all outputs as above.
//  2. flush_ie: bubble. valid_ie=0; all *_ie control bits=0; data fields=0.
//  3. hold_ie: every *_ie output and valid_ie keep their values.
//  4. hazard_stall_id: bubble, as in rule 2.
//     - The load leaves EX on the same edge, so the stall lasts exactly 1 cycle.
//     - The dependent instruction, still in decode, is captured on the next edge.
//  5. Otherwise load: *_ie <= *_id and valid_ie <= valid_id.
//     - When valid_id=0, control bits are written as 0.
//  Bubble invariant: valid_ie=0 implies reg_write_ie, mem_write_ie, mem_read_ie,
//    branch_ie and uncond_branch_ie are all 0.
//  Boundary rules:
//  - Load into XZR never stalls.
//  - rn==rm==load destination still gives a single 1-cycle stall.
//  - hold_ie and flush_ie together resolve as flush.
//  - reset mid-hazard drops the stall on the next cycle.
// CONFIGURATION
//  ID_EX_PERF_EN defined:
//  - bubble_count increments on each rule-4 bubble.
//  - flush_count increments on each rule-2 edge where valid_ie or valid_id was 1.
//  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
//  ID_EX_PERF_EN undefined:
//  - Counters are not built.
//  - bubble_count and flush_count are tied to 32'd0.
//  - All other behaviour is identical.
// TESTING
//  1. Reset: hold reset for 2 cycles with random *_id -> every *_ie, valid_ie and counter read 0.
//  2. Pass-through: valid ADD, pc=0x10, rd=3, reg_write=1 -> next cycle cur_pc_ie=0x10,
//     write_register_ie=3, reg_write_ie=1, valid_ie=1.
//  3. Load-use: LDUR X2 now in EX (mem_read_ie=1), decode ADD rn=2
//     -> hazard_stall_id=1 for one cycle; a bubble is inserted (valid_ie=0, reg_write_ie=0);
//     the ADD is captured on the next edge; bubble_count=1 with ID_EX_PERF_EN.
//  4. XZR load: LDUR X31 in EX, decode rn=31 -> hazard_stall_id=0, no bubble.
//  5. Flush vs hold: flush_ie=1 and hold_ie=1 on the same edge -> valid_ie=0, all controls 0;
//     hold alone over 3 cycles -> outputs unchanged.
//  6. Perf off: rebuild without ID_EX_PERF_EN and rerun test 3 -> bubble_count stays 0.

Source files
------------

// File: rtl/id_ex_buffer.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and external hold.
// Optional performance counters are built when ID_EX_PERF_EN is defined.
module id_ex_buffer #(
    parameter int WORD_W   = 64,
    parameter int OPC_W    = 11,
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_id,
    input  logic              uncond_branch_id,
    input  logic              branch_id,
    input  logic              mem_read_id,
    input  logic              mem_to_reg_id,
    input  logic              mem_write_id,
    input  logic              reg_write_id,
    input  logic              ALU_src_id,
    input  logic [1:0]        ALU_op_id,
    input  logic [OPC_W-1:0]  opcode_id,
    input  logic [REG_W-1:0]  read_reg1_id,
    input  logic [REG_W-1:0]  read_reg2_id,
    input  logic [REG_W-1:0]  write_register_id,
    input  logic [WORD_W-1:0] cur_pc_id,
    input  logic [WORD_W-1:0] read_data1_id,
    input  logic [WORD_W-1:0] read_data2_id,
    input  logic [WORD_W-1:0] sign_extended_output_id,
    input  logic              flush_ie,
    input  logic              hold_ie,
    output logic              valid_ie,
    output logic              uncond_branch_ie,
    output logic              branch_ie,
    output logic              mem_read_ie,
    output logic              mem_to_reg_ie,
    output logic              mem_write_ie,
    output logic              reg_write_ie,
    output logic              ALU_src_ie,
    output logic [1:0]        ALU_op_ie,
    output logic [OPC_W-1:0]  opcode_ie,
    output logic [REG_W-1:0]  read_reg1_ie,
    output logic [REG_W-1:0]  read_reg2_ie,
    output logic [REG_W-1:0]  write_register_ie,
    output logic [WORD_W-1:0] cur_pc_ie,
    output logic [WORD_W-1:0] read_data1_ie,
    output logic [WORD_W-1:0] read_data2_ie,
    output logic [WORD_W-1:0] sign_extended_output_ie,
    output logic              hazard_stall_id,
    output logic [31:0]       bubble_count,
    output logic [31:0]       flush_count
);

    logic load_use;
    logic dst_match;

    assign dst_match = (write_register_ie == read_reg1_id) || (write_register_ie == read_reg2_id);
    assign load_use  = valid_ie && mem_read_ie && valid_id
                     && (write_register_ie != REG_W'(ZERO_REG)) && dst_match;
    assign hazard_stall_id = load_use && !hold_ie && !flush_ie;

    // hazard_stall_id is already masked by hold/flush, so one clear branch covers reset, flush and bubble.
    always_ff @(posedge clk) begin
        if (reset || flush_ie || hazard_stall_id) begin
            valid_ie                <= 1'b0;
            uncond_branch_ie        <= 1'b0;
            branch_ie               <= 1'b0;
            mem_read_ie             <= 1'b0;
            mem_to_reg_ie           <= 1'b0;
            mem_write_ie            <= 1'b0;
            reg_write_ie            <= 1'b0;
            ALU_src_ie              <= 1'b0;
            ALU_op_ie               <= '0;
            opcode_ie               <= '0;
            read_reg1_ie            <= '0;
            read_reg2_ie            <= '0;
            write_register_ie       <= '0;
            cur_pc_ie               <= '0;
            read_data1_ie           <= '0;
            read_data2_ie           <= '0;
            sign_extended_output_ie <= '0;
        end else if (!hold_ie) begin
            valid_ie                <= valid_id;
            uncond_branch_ie        <= uncond_branch_id && valid_id;
            branch_ie               <= branch_id && valid_id;
            mem_read_ie             <= mem_read_id && valid_id;
            mem_to_reg_ie           <= mem_to_reg_id && valid_id;
            mem_write_ie            <= mem_write_id && valid_id;
            reg_write_ie            <= reg_write_id && valid_id;
            ALU_src_ie              <= ALU_src_id && valid_id;
            ALU_op_ie               <= ALU_op_id & {2{valid_id}};
            opcode_ie               <= opcode_id;
            read_reg1_ie            <= read_reg1_id;
            read_reg2_ie            <= read_reg2_id;
            write_register_ie       <= write_register_id;
            cur_pc_ie               <= cur_pc_id;
            read_data1_ie           <= read_data1_id;
            read_data2_ie           <= read_data2_id;
            sign_extended_output_ie <= sign_extended_output_id;
        end
    end

`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            if (hazard_stall_id && (bubble_q != '1))
                bubble_q <= bubble_q + 32'd1;
            if (flush_ie && (valid_ie || valid_id) && (flush_q != '1))
                flush_q <= flush_q + 32'd1;
        end
    end

    assign bubble_count = bubble_q;
    assign flush_count  = flush_q;
`else
    assign bubble_count = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_id_ex_buffer.sv
// Bench for id_ex_buffer: directed vector table followed by random stimulus against a slot-level model.
module tb_id_ex_buffer;

`ifdef ID_EX_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic        ub;
        logic        b;
        logic        mr;
        logic        m2r;
        logic        mw;
        logic        rw;
        logic        as;
        logic [1:0]  op;
        logic [10:0] opcode;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [4:0]  wr;
        logic [63:0] pc;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] sx;
    } slot_t;

    typedef struct packed {
        logic  reset;
        logic  flush;
        logic  hold;
        slot_t s;
    } in_t;

    typedef struct {
        in_t         i;
        bit          hz;
        bit          v;
        bit          rw;
        logic [63:0] pc;
        logic [4:0]  wr;
    } vec_t;

    logic        clk;
    in_t         cur;
    slot_t       act;
    logic        hazard_stall_id;
    logic [31:0] bubble_count;
    logic [31:0] flush_count;

    logic        valid_ie, uncond_branch_ie, branch_ie, mem_read_ie, mem_to_reg_ie;
    logic        mem_write_ie, reg_write_ie, ALU_src_ie;
    logic [1:0]  ALU_op_ie;
    logic [10:0] opcode_ie;
    logic [4:0]  read_reg1_ie, read_reg2_ie, write_register_ie;
    logic [63:0] cur_pc_ie, read_data1_ie, read_data2_ie, sign_extended_output_ie;

    assign act = {valid_ie, uncond_branch_ie, branch_ie, mem_read_ie, mem_to_reg_ie,
                  mem_write_ie, reg_write_ie, ALU_src_ie, ALU_op_ie, opcode_ie,
                  read_reg1_ie, read_reg2_ie, write_register_ie, cur_pc_ie,
                  read_data1_ie, read_data2_ie, sign_extended_output_ie};

    id_ex_buffer #(.WORD_W(64), .OPC_W(11), .REG_W(5), .ZERO_REG(31)) dut (
        .clk(clk), .reset(cur.reset),
        .valid_id(cur.s.valid), .uncond_branch_id(cur.s.ub), .branch_id(cur.s.b),
        .mem_read_id(cur.s.mr), .mem_to_reg_id(cur.s.m2r), .mem_write_id(cur.s.mw),
        .reg_write_id(cur.s.rw), .ALU_src_id(cur.s.as), .ALU_op_id(cur.s.op),
        .opcode_id(cur.s.opcode), .read_reg1_id(cur.s.rr1), .read_reg2_id(cur.s.rr2),
        .write_register_id(cur.s.wr), .cur_pc_id(cur.s.pc), .read_data1_id(cur.s.rd1),
        .read_data2_id(cur.s.rd2), .sign_extended_output_id(cur.s.sx),
        .flush_ie(cur.flush), .hold_ie(cur.hold),
        .valid_ie(valid_ie), .uncond_branch_ie(uncond_branch_ie), .branch_ie(branch_ie),
        .mem_read_ie(mem_read_ie), .mem_to_reg_ie(mem_to_reg_ie), .mem_write_ie(mem_write_ie),
        .reg_write_ie(reg_write_ie), .ALU_src_ie(ALU_src_ie), .ALU_op_ie(ALU_op_ie),
        .opcode_ie(opcode_ie), .read_reg1_ie(read_reg1_ie), .read_reg2_ie(read_reg2_ie),
        .write_register_ie(write_register_ie), .cur_pc_ie(cur_pc_ie),
        .read_data1_ie(read_data1_ie), .read_data2_ie(read_data2_ie),
        .sign_extended_output_ie(sign_extended_output_ie),
        .hazard_stall_id(hazard_stall_id), .bubble_count(bubble_count),
        .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    slot_t       m;
    int unsigned bub = 0;
    int unsigned fl = 0;

    task automatic check(input string name, input logic [299:0] got, input logic [299:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic slot_t rand_slot();
        slot_t s;
        s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom};
        return s;
    endfunction

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 4) == 4) ? 5'd31 : 5'($urandom_range(0, 2));
    endfunction

    function automatic slot_t ins(bit v, bit mr, bit rw, int rn, int rm, int wr, logic [63:0] pc);
        slot_t s;
        s        = '0;
        s.valid  = v;
        s.mr     = mr;
        s.m2r    = mr;
        s.rw     = rw;
        s.as     = mr;
        s.op     = mr ? 2'b00 : 2'b10;
        s.opcode = mr ? 11'h7C2 : 11'h458;
        s.rr1    = 5'(rn);
        s.rr2    = 5'(rm);
        s.wr     = 5'(wr);
        s.pc     = pc;
        s.rd1    = pc ^ 64'hA5;
        s.rd2    = pc + 64'd7;
        s.sx     = pc << 1;
        return s;
    endfunction

    function automatic vec_t mk(bit r, bit f, bit h, slot_t s, bit hz, bit v, bit rw,
                                logic [63:0] pc, int wr);
        vec_t t;
        t.i  = {r, f, h, s};
        t.hz = hz;
        t.v  = v;
        t.rw = rw;
        t.pc = pc;
        t.wr = 5'(wr);
        return t;
    endfunction

    // A load sitting in EX blocks a decode instruction that reads its destination, unless XZR.
    function automatic bit exp_hz(slot_t ex, in_t i);
        if (i.hold || i.flush) return 1'b0;
        if (!(ex.valid && ex.mr && i.s.valid)) return 1'b0;
        if (ex.wr == 5'd31) return 1'b0;
        return (ex.wr == i.s.rr1) || (ex.wr == i.s.rr2);
    endfunction

    function automatic void model_edge(in_t i);
        bit hz;
        hz = exp_hz(m, i);
        if (i.reset) begin
            m = '0; bub = 0; fl = 0;
        end else if (i.flush) begin
            if ((m.valid || i.s.valid) && fl != 32'hFFFF_FFFF) fl++;
            m = '0;
        end else if (i.hold) begin
            m = m;
        end else if (hz) begin
            m = '0;
            if (bub != 32'hFFFF_FFFF) bub++;
        end else begin
            m = i.s;
            if (!i.s.valid) begin
                m.ub = 0; m.b = 0; m.mr = 0; m.m2r = 0; m.mw = 0; m.rw = 0; m.as = 0; m.op = '0;
            end
        end
    endfunction

    task automatic apply(input in_t i);
        cur = i;
        #1;
        check("hazard_stall_id", 300'(hazard_stall_id), 300'(exp_hz(m, i)));
        @(posedge clk);
        model_edge(i);
        @(negedge clk);
        check("ex_slot", 300'(act), 300'(m));
        check("bubble_count", 300'(bubble_count), PERF ? 300'(bub) : 300'(0));
        check("flush_count", 300'(flush_count), PERF ? 300'(fl) : 300'(0));
    endtask

    vec_t tbl[$];

    initial begin
        m   = '0;
        cur = {1'b1, 1'b0, 1'b0, rand_slot()};
        @(posedge clk);
        @(negedge clk);

        tbl.push_back(mk(1, 0, 0, rand_slot(),                   0, 0, 0, 64'h0,  0));
        tbl.push_back(mk(1, 0, 0, rand_slot(),                   0, 0, 0, 64'h0,  0));
        tbl.push_back(mk(0, 0, 0, ins(1, 0, 1, 1, 4, 3, 64'h10), 0, 1, 1, 64'h10, 3));
        tbl.push_back(mk(0, 0, 0, ins(1, 1, 1, 5, 5, 2, 64'h14), 0, 1, 1, 64'h14, 2));
        tbl.push_back(mk(0, 0, 0, ins(1, 0, 1, 2, 6, 7, 64'h18), 1, 0, 0, 64'h0,  0));
        tbl.push_back(mk(0, 0, 0, ins(1, 0, 1, 2, 6, 7, 64'h18), 0, 1, 1, 64'h18, 7));
        tbl.push_back(mk(0, 0, 0, ins(1, 1, 1, 5, 5, 31, 64'h1c), 0, 1, 1, 64'h1c, 31));
        tbl.push_back(mk(0, 0, 0, ins(1, 0, 1, 31, 31, 8, 64'h20), 0, 1, 1, 64'h20, 8));
        tbl.push_back(mk(0, 0, 0, ins(1, 1, 1, 5, 5, 9, 64'h24), 0, 1, 1, 64'h24, 9));
        tbl.push_back(mk(0, 0, 0, ins(1, 0, 1, 9, 9, 10, 64'h28), 1, 0, 0, 64'h0, 0));
        tbl.push_back(mk(0, 0, 0, ins(1, 0, 1, 9, 9, 10, 64'h28), 0, 1, 1, 64'h28, 10));
        tbl.push_back(mk(0, 1, 1, ins(1, 0, 1, 1, 1, 4, 64'h2c), 0, 0, 0, 64'h0,  0));
        tbl.push_back(mk(0, 0, 0, ins(1, 0, 1, 1, 2, 11, 64'h30), 0, 1, 1, 64'h30, 11));
        tbl.push_back(mk(0, 0, 1, ins(1, 0, 0, 3, 3, 5, 64'h99), 0, 1, 1, 64'h30, 11));
        tbl.push_back(mk(0, 0, 1, ins(1, 1, 1, 4, 4, 6, 64'h9a), 0, 1, 1, 64'h30, 11));
        tbl.push_back(mk(0, 0, 1, ins(0, 0, 0, 0, 0, 0, 64'h9b), 0, 1, 1, 64'h30, 11));
        tbl.push_back(mk(0, 0, 0, ins(1, 1, 1, 5, 5, 12, 64'h34), 0, 1, 1, 64'h34, 12));
        tbl.push_back(mk(1, 0, 0, ins(1, 0, 1, 12, 0, 14, 64'h38), 1, 0, 0, 64'h0, 0));
        tbl.push_back(mk(0, 0, 0, ins(1, 0, 1, 12, 0, 14, 64'h38), 0, 1, 1, 64'h38, 14));
        tbl.push_back(mk(0, 0, 0, ins(1, 1, 1, 5, 5, 13, 64'h3c), 0, 1, 1, 64'h3c, 13));
        tbl.push_back(mk(0, 0, 1, ins(1, 0, 1, 13, 13, 15, 64'h3e), 0, 1, 1, 64'h3c, 13));
        tbl.push_back(mk(0, 0, 0, ins(0, 1, 1, 1, 1, 16, 64'h40), 0, 0, 0, 64'h40, 16));

        foreach (tbl[k]) begin
            cur = tbl[k].i;
            #1;
            check($sformatf("vec%0d_hz", k), 300'(hazard_stall_id), 300'(tbl[k].hz));
            cur = tbl[k].i;
            #0;
            apply(tbl[k].i);
            check($sformatf("vec%0d_valid", k), 300'(valid_ie), 300'(tbl[k].v));
            check($sformatf("vec%0d_reg_write", k), 300'(reg_write_ie), 300'(tbl[k].rw));
            check($sformatf("vec%0d_pc", k), 300'(cur_pc_ie), 300'(tbl[k].pc));
            check($sformatf("vec%0d_wr", k), 300'(write_register_ie), 300'(tbl[k].wr));
            if (k == 4)
                check("load_use_bubble_count", 300'(bubble_count), PERF ? 300'(1) : 300'(0));
            if (k == 11)
                check("flush_hold_mem_read", 300'(mem_read_ie), 300'(0));
        end

        for (int n = 0; n < 400; n++) begin
            in_t r;
            r.s       = rand_slot();
            r.s.valid = ($urandom_range(0, 9) != 0);
            r.s.mr    = ($urandom_range(0, 9) < 4);
            r.s.rr1   = pick_reg();
            r.s.rr2   = pick_reg();
            r.s.wr    = pick_reg();
            r.reset   = ($urandom_range(0, 49) == 0);
            r.flush   = ($urandom_range(0, 9) == 0);
            r.hold    = ($urandom_range(0, 6) == 0);
            apply(r);
            if (!valid_ie)
                check("bubble_invariant", 300'({reg_write_ie, mem_write_ie, mem_read_ie,
                                                branch_ie, uncond_branch_ie}), 300'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
